seg_scan_ctl: RTL and testbench
===============================

# seg_scan_ctl

Parametrised N-digit multiplexed seven-segment display controller. It accepts a binary value over a load/ready handshake and converts it to BCD with a sequential double-dabble engine. It then scans the digits one at a time onto a shared segment bus with a programmable dwell time. It adds per-digit decimal points, overflow indication and optional leading-zero blanking, and replaces the fixed 4-digit display path in the timer top level.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8.
- NUM_W, 16, width of binary input; legal range 4..32.
- DWELL, 1, ms_clock cycles each digit stays selected; must be ≥ 1.
- PORT_W, derived, max(1, clog2(DIGITS)); not to be overridden.
- ms_clock  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- number  in  NUM_W  unsigned value to display; sampled on load acceptance.
- load  in  1  request; accepted on a rising edge where load=1 and ready=1.
- dp_mask  in  DIGITS  decimal-point enable per digit (bit i = digit i); sampled with number.
- ready  out  1  high when idle and able to accept load.
- ovf  out  1  committed value ≥ 10^DIGITS.
- port  out  PORT_W  index of the currently driven digit; 0 = least significant.
- pattern  out  8  segments for digit `port`, active-high: [7]=dp, [6:0]=g..a.

## Operation
- Conversion FSM has three states.
  - IDLE: ready=1. An accepted load latches number into a shift register and dp_mask into a pending register, clears the BCD accumulator, and moves to CONV.
  - CONV: runs exactly NUM_W cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift left one bit, bringing in the binary MSB. After the last shift, move to COMMIT.
  - COMMIT: copies the low DIGITS nibbles and the pending dp into the display registers and sets ovf. Returns to IDLE.
- The accumulator holds (NUM_W+2)/3 nibbles, using integer division. ovf=1 when any nibble at index ≥ DIGITS is non-zero.
- load while ready=0 is ignored. It is neither queued nor does it alter the conversion in progress.
- Scan logic runs continuously and independently of the FSM.
  - A dwell counter counts 0..DWELL-1.
  - On terminal count, port increments and wraps DIGITS-1 → 0.
- Segment codes:
  - Digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
  - Non-decimal nibbles are unreachable.
  - Bit 7 is OR'd with dp of the driven digit.
- Overflow: while ovf=1, every digit shows 8'h40 ("-") with dp suppressed.
- pattern and port are both registered and always correspond to each other in the same cycle.

## Timing
- Reset state: FSM=IDLE, ready=1, ovf=0, port=0, dwell=0, display digits=0, dp=0, pattern=8'h3F.
- rst has priority over load. A load asserted in the same cycle as rst is dropped.
- rst during CONV or COMMIT aborts the conversion. The display returns to the reset state on the next edge.
- Load accepted at edge k:
  - ready=0 from after edge k.
  - CONV occupies edges k+1..k+NUM_W.
  - COMMIT occurs at edge k+NUM_W+1. Display registers, ovf and ready=1 all update together at that edge.
  - ready is therefore low for exactly NUM_W+1 cycles.
- Earliest next acceptance is edge k+NUM_W+2.
- pattern reflects the new value starting with the pattern register update after commit. There is no partial or torn digit set.
- Scan timing: port changes every DWELL cycles. With DWELL=1 it changes every cycle. A full frame is DIGITS·DWELL cycles.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking is active.
  - Digit i ≥ 1 is blanked (segments [6:0]=0) when digits i..DIGITS-1 are all zero.
  - Its dp bit is still driven from dp_mask.
  - Digit 0 is never blanked.
  - Has no effect while ovf=1.
- SEG_LZB_EN undefined: all digits always show their value, including leading zeros. Port list and timing are identical in both builds.

## Test plan
- Reset, DIGITS=4, DWELL=2 → port sequence 0,0,1,1,2,2,3,3,0,…; pattern 8'h3F on every cycle; ready=1; ovf=0.
- Load number=1234, dp_mask=0, NUM_W=16 → ready low for 17 cycles. Afterwards port 0/1/2/3 show 66/4F/5B/06, ovf=0.
- Load 10000 → ovf=1, all digits 8'h40. Then load 9999 → ovf=0, all digits 8'h6F.
- Load 7 with dp_mask=4'b0100:
  - With SEG_LZB_EN → port0=07, port1=00, port2=80, port3=00.
  - Without SEG_LZB_EN → 07, 3F, BF, 3F.
- Load asserted on every cycle during a conversion → only the first value is committed; no extra busy period follows.
- rst asserted mid-CONV together with load → next cycle ready=1, port=0, pattern=8'h3F, ovf=0. No commit occurs.

Source files
------------

// File: rtl/seg_scan_if.sv
// Load/ready handshake and scanned segment bus for seg_scan_ctl.
interface seg_scan_if #(
    parameter int DIGITS = 4,
    parameter int NUM_W  = 16
);
    localparam int PORT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [NUM_W-1:0]  number;
    logic              load;
    logic [DIGITS-1:0] dp_mask;
    logic              ready;
    logic              ovf;
    logic [PORT_W-1:0] port;
    logic [7:0]        pattern;

    modport master (
        output number, load, dp_mask,
        input  ready, ovf, port, pattern
    );

    modport slave (
        input  number, load, dp_mask,
        output ready, ovf, port, pattern
    );
endinterface

// File: rtl/seg_scan_ctl.sv
// N-digit multiplexed 7-segment controller with double-dabble BCD conversion.
// Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_ctl #(
    parameter int DIGITS = 4,
    parameter int NUM_W  = 16,
    parameter int DWELL  = 1
) (
    input logic      ms_clock,
    input logic      rst,
    seg_scan_if.slave bus
);
    localparam int PORT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIB    = (NUM_W + 2) / 3;
    localparam int AW     = 4 * NIB;
    localparam int PW     = (NIB > DIGITS) ? AW : 4 * DIGITS;
    localparam int CW     = $clog2(NUM_W + 1);
    localparam int DW     = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t              state;
    logic [NUM_W-1:0]    shift;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_adj;
    logic [PW-1:0]       acc_pad;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   dp_pend;
    logic [DIGITS-1:0]   dp_disp;
    logic [4*DIGITS-1:0] disp;
    logic                ovf_q;
    logic                ready_q;
    logic [DW-1:0]       dwell;
    logic [PORT_W-1:0]   port_q;
    logic [PORT_W-1:0]   port_nx;
    logic [7:0]          pat_q;
    logic [7:0]          pat_nx;
    int                  p;
    logic [3:0]          nib;
    logic [6:0]          seg;
`ifdef SEG_LZB_EN
    logic                hi_zero;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < NIB; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    assign acc_pad = PW'(acc);

    always_ff @(posedge ms_clock) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
            disp    <= '0;
            dp_disp <= '0;
            dp_pend <= '0;
            shift   <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.load) begin
                    shift   <= bus.number;
                    dp_pend <= bus.dp_mask;
                    acc     <= '0;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                    state   <= CONV;
                end
                CONV: begin
                    acc   <= AW'({acc_adj, shift[NUM_W-1]});
                    shift <= shift << 1;
                    if (cnt == CW'(NUM_W - 1))
                        state <= COMMIT;
                    else
                        cnt <= cnt + 1'b1;
                end
                COMMIT: begin
                    disp    <= acc_pad[4*DIGITS-1:0];
                    dp_disp <= dp_pend;
                    ovf_q   <= (acc_pad >> (4 * DIGITS)) != '0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        port_nx = port_q;
        if (dwell == DW'(DWELL - 1))
            port_nx = (port_q == PORT_W'(DIGITS - 1)) ? '0 : port_q + 1'b1;
    end

    // Pattern is computed for the port value being registered alongside it.
    always_comb begin
        p   = int'(port_nx);
        nib = disp[4*p +: 4];
        seg = seg7(nib);
`ifdef SEG_LZB_EN
        hi_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= p && disp[4*j +: 4] != 4'd0)
                hi_zero = 1'b0;
        end
        if (p != 0 && hi_zero)
            seg = 7'h00;
`endif
        pat_nx = {dp_disp[p], seg};
        if (ovf_q)
            pat_nx = 8'h40;
    end

    always_ff @(posedge ms_clock) begin
        if (rst) begin
            dwell  <= '0;
            port_q <= '0;
            pat_q  <= 8'h3F;
        end else begin
            dwell  <= (dwell == DW'(DWELL - 1)) ? '0 : dwell + 1'b1;
            port_q <= port_nx;
            pat_q  <= pat_nx;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.ovf     = ovf_q;
    assign bus.port    = port_q;
    assign bus.pattern = pat_q;
endmodule

// File: tb/tb_seg_scan_ctl.sv
// Self-checking bench for seg_scan_ctl against an arithmetic display model.
module tb_seg_scan_ctl;
    localparam int DIGITS = 4;
    localparam int NUM_W  = 16;
    localparam int DWELL  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_if #(.DIGITS(DIGITS), .NUM_W(NUM_W)) bus ();

    seg_scan_ctl #(.DIGITS(DIGITS), .NUM_W(NUM_W), .DWELL(DWELL)) dut (
        .ms_clock(clk),
        .rst     (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int since_rst = 0;
    longint exp_val = 0;
    logic [DIGITS-1:0] exp_dp = '0;
    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic exp_ovf();
        return exp_val >= pow10(DIGITS);
    endfunction

    function automatic logic [7:0] exp_pat(input int p);
        logic [7:0] s;
        if (exp_ovf()) return 8'h40;
        s = seg_tab[int'((exp_val / pow10(p)) % 10)];
`ifdef SEG_LZB_EN
        if (p >= 1 && exp_val < pow10(p)) s = 8'h00;
`endif
        s[7] = exp_dp[p];
        return s;
    endfunction

    task automatic start_load(input logic [NUM_W-1:0] v,
                              input logic [DIGITS-1:0] dp);
        @(negedge clk);
        bus.number  = v;
        bus.dp_mask = dp;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        int ep;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2 * DIGITS * DWELL; i++) begin
            ep = (i / DWELL) % DIGITS;
            checks++;
            if (int'(bus.port) !== ep) begin
                errors++;
                $display("FAIL reset_port[%0d]: got %0d want %0d", i, bus.port, ep);
            end
            checks++;
            if (bus.pattern !== 8'h3F) begin
                errors++;
                $display("FAIL reset_pattern[%0d]: got %h want 3f", i, bus.pattern);
            end
            checks++;
            if (bus.ready !== 1'b1 || bus.ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags[%0d]: ready=%b ovf=%b want 1 0",
                         i, bus.ready, bus.ovf);
            end
            if (i == 0) rst = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_conversion();
        logic [NUM_W-1:0]  vals [$];
        logic [DIGITS-1:0] dps  [$];
        int low;
        int ep;
        vals = '{16'd1234, 16'd10000, 16'd9999, 16'd7, 16'd0, 16'd65535};
        dps  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1001, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            vals.push_back(16'($urandom_range(0, 65535)));
            dps.push_back(4'($urandom_range(0, 15)));
        end
        for (int n = 0; n < vals.size(); n++) begin
            start_load(vals[n], dps[n]);
            exp_val = longint'(vals[n]);
            exp_dp  = dps[n];
            low = 0;
            while (!bus.ready && low < 100) begin
                low++;
                @(posedge clk);
                #1;
            end
            checks++;
            if (low !== NUM_W + 1) begin
                errors++;
                $display("FAIL busy_len(%0d): got %0d want %0d", vals[n], low, NUM_W + 1);
            end
            checks++;
            if (bus.ovf !== exp_ovf()) begin
                errors++;
                $display("FAIL ovf(%0d): got %b want %b", vals[n], bus.ovf, exp_ovf());
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < DIGITS * DWELL; c++) begin
                ep = (since_rst / DWELL) % DIGITS;
                checks++;
                if (int'(bus.port) !== ep || bus.pattern !== exp_pat(ep)) begin
                    errors++;
                    $display("FAIL digit(%0d): port=%0d pat=%h want port=%0d pat=%h",
                             vals[n], bus.port, bus.pattern, ep, exp_pat(ep));
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_W-1:0] first;
        int low;
        int ep;
        first = 16'($urandom_range(0, 9999));
        @(negedge clk);
        bus.number  = first;
        bus.dp_mask = 4'b0010;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        exp_val = longint'(first);
        exp_dp  = 4'b0010;
        low = 0;
        while (!bus.ready && low < 100) begin
            low++;
            bus.number  = 16'($urandom);
            bus.dp_mask = 4'($urandom);
            @(posedge clk);
            #1;
        end
        bus.load = 1'b0;
        checks++;
        if (low !== NUM_W + 1) begin
            errors++;
            $display("FAIL b2b_busy: got %0d want %0d", low, NUM_W + 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_requeue: ready=%b want 1", bus.ready);
        end
        for (int c = 0; c < DIGITS * DWELL; c++) begin
            ep = (since_rst / DWELL) % DIGITS;
            checks++;
            if (int'(bus.port) !== ep || bus.pattern !== exp_pat(ep)) begin
                errors++;
                $display("FAIL b2b_digit: port=%0d pat=%h want port=%0d pat=%h",
                         bus.port, bus.pattern, ep, exp_pat(ep));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int busy;
        int ep;
        start_load(16'd54321, 4'b1111);
        t = 0;
        while (!bus.ready && t < 100) begin
            t++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_ovf: got %b want 1", bus.ovf);
        end
        start_load(16'd1111, 4'b0101);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        bus.load    = 1'b1;
        bus.number  = 16'd555;
        bus.dp_mask = 4'b1111;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.ovf !== 1'b0 ||
            bus.port !== '0 || bus.pattern !== 8'h3F) begin
            errors++;
            $display("FAIL mid_rst: ready=%b ovf=%b port=%0d pat=%h want 1 0 0 3f",
                     bus.ready, bus.ovf, bus.port, bus.pattern);
        end
        @(negedge clk);
        rst      = 1'b0;
        bus.load = 1'b0;
        exp_val  = 0;
        exp_dp   = '0;
        busy = 0;
        repeat (NUM_W + 4) begin
            @(posedge clk);
            #1;
            if (!bus.ready) busy++;
        end
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL mid_rst_no_commit: busy cycles %0d want 0", busy);
        end
        for (int c = 0; c < DIGITS * DWELL; c++) begin
            ep = (since_rst / DWELL) % DIGITS;
            checks++;
            if (int'(bus.port) !== ep || bus.pattern !== exp_pat(ep) || bus.ovf !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_digit: port=%0d pat=%h ovf=%b want port=%0d pat=%h ovf=0",
                         bus.port, bus.pattern, bus.ovf, ep, exp_pat(ep));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.load    = 1'b0;
        bus.number  = '0;
        bus.dp_mask = '0;
        test_reset();
        test_conversion();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
